// File: rtl/mimasuo_pkg.sv
// Shared types and defaults for the mimasuo key-conditioning front end.
// Holds the per-key debounce state encoding and the default timing constants.
package mimasuo_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int DEF_SYNC_STAGES     = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;

    function automatic int cnt_width(input int cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/mimasuo_key_debounce.sv
// One key: synchroniser chain, debounce FSM with stability counter, and
// registered single-cycle press pulse plus debounced level.
module mimasuo_key_debounce
    import mimasuo_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic press_pulse,
    output logic held
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    // With a one-cycle debounce the wait states must exit on their first
    // cycle, so the entry count starts at the terminal value instead of 1.
    localparam logic [CNT_W-1:0] CNT_START = CNT_W'((DEBOUNCE_CYCLES > 1) ? 1 : 0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] vld_q;
    logic                   s;
    logic                   sync_ok;

    key_state_e             state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   armed_q, armed_d;
    logic                   pulse_q, pulse_d;
    logic                   held_q, held_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            vld_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], key_raw};
            vld_q  <= {vld_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign s       = sync_q[SYNC_STAGES-1];
    // s only reflects the real key once the chain has refilled after reset.
    assign sync_ok = vld_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            armed_q <= 1'b0;
            pulse_q <= 1'b0;
            held_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            armed_q <= armed_d;
            pulse_q <= pulse_d;
            held_q  <= held_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        armed_d = armed_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                // A key held through reset must be seen released before it may qualify.
                if (!armed_q) begin
                    if (sync_ok && !s) begin
                        armed_d = 1'b1;
                    end
                end else if (s) begin
                    cnt_d   = CNT_START;
                    state_d = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    pulse_d = 1'b1;
                    state_d = HELD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    cnt_d   = CNT_START;
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        held_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    assign press_pulse = pulse_q;
    assign held        = held_q;

endmodule

// File: rtl/mimasuo_key_cond.sv
// Two-key conditioning stage feeding the mimasuo_logic lock FSM: one clean
// pulse per accepted press on button0/button1, plus debounced key levels.
module mimasuo_key_cond
    import mimasuo_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key0_raw,
    input  logic       key1_raw,
    output logic       button0,
    output logic       button1,
    output logic [1:0] key_held
);

    logic [1:0] raw_w;
    logic [1:0] pulse_w;
    logic [1:0] held_w;

    assign raw_w = {key1_raw, key0_raw};

    // Keys are fully independent; simultaneous presses yield code 2'b11.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_key
            mimasuo_key_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_deb (
                .clk         (clk),
                .rst         (rst),
                .key_raw     (raw_w[gi]),
                .press_pulse (pulse_w[gi]),
                .held        (held_w[gi])
            );
        end
    endgenerate

    assign button0  = pulse_w[0];
    assign button1  = pulse_w[1];
    assign key_held = held_w;

endmodule

// File: tb/tb_mimasuo_key_cond.sv
// Directed bench for mimasuo_key_cond: expected pulses are queued when a
// clean rise is driven and matched against observed pulses by a monitor.
module tb_mimasuo_key_cond;

    logic       clk = 1'b0;
    logic       rst;
    logic       key0_raw;
    logic       key1_raw;
    logic       button0;
    logic       button1;
    logic [1:0] key_held;

    typedef struct {
        int         cyc;
        logic [1:0] code;
    } exp_t;

    exp_t sb[$];
    int   cyc      = 0;
    int   n_assert = 0;
    int   n_fail   = 0;

    // Rise driven at negedge with cycle count n: sync capture at edge n+1,
    // pulse visible after edge n+6.
    localparam int PULSE_LAT = 6;

    mimasuo_key_cond dut (
        .clk      (clk),
        .rst      (rst),
        .key0_raw (key0_raw),
        .key1_raw (key1_raw),
        .button0  (button0),
        .button1  (button1),
        .key_held (key_held)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        exp_t e;
        if (button0 || button1) begin
            if (sb.size() == 0) begin
                n_assert++;
                assert ({button1, button0} === 2'b00) else begin
                    n_fail++;
                    $error("FAIL unexpected_pulse cyc=%0d observed=%b expected=00", cyc, {button1, button0});
                end
            end else begin
                e = sb.pop_front();
                n_assert++;
                assert (cyc === e.cyc) else begin
                    n_fail++;
                    $error("FAIL pulse_cycle observed=%0d expected=%0d", cyc, e.cyc);
                end
                n_assert++;
                assert ({button1, button0} === e.code) else begin
                    n_fail++;
                    $error("FAIL pulse_code cyc=%0d observed=%b expected=%b", cyc, {button1, button0}, e.code);
                end
            end
        end else if (sb.size() > 0 && cyc > sb[0].cyc) begin
            e = sb.pop_front();
            n_assert++;
            assert ({button1, button0} === e.code) else begin
                n_fail++;
                $error("FAIL missed_pulse cyc=%0d observed=%b expected=%b", e.cyc, {button1, button0}, e.code);
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic expect_pulse(input logic [1:0] code);
        exp_t e;
        e.cyc  = cyc + PULSE_LAT;
        e.code = code;
        sb.push_back(e);
        $display("expect pulse code=%b at cyc=%0d", code, e.cyc);
    endtask

    initial begin
        rst      = 1'b1;
        key0_raw = 1'b1;
        key1_raw = 1'b1;

        // Reset with both keys held: everything quiet, no pulse on release.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_buttons", {30'd0, button1, button0}, 32'd0);
            check("rst_held", {30'd0, key_held}, 32'd0);
        end
        rst = 1'b0;
        wait_cycles(15);
        check("post_rst_held", {30'd0, key_held}, 32'd0);
        key0_raw = 1'b0;
        key1_raw = 1'b0;
        wait_cycles(10);
        key0_raw = 1'b1;
        key1_raw = 1'b1;
        expect_pulse(2'b11);
        wait_cycles(12);
        check("rearm_held", {30'd0, key_held}, 32'd3);
        key0_raw = 1'b0;
        key1_raw = 1'b0;
        wait_cycles(12);
        check("rearm_release", {30'd0, key_held}, 32'd0);

        // Clean press on key0 with exact held timing.
        key0_raw = 1'b1;
        expect_pulse(2'b01);
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            check("clean_held0", {31'd0, key_held[0]}, (i >= PULSE_LAT) ? 32'd1 : 32'd0);
        end
        check("clean_held1", {31'd0, key_held[1]}, 32'd0);
        key0_raw = 1'b0;
        wait_cycles(12);
        check("clean_release", {30'd0, key_held}, 32'd0);

        // Bounce on key1, then a stable rise.
        for (int i = 0; i < 8; i++) begin
            key1_raw = (i % 2 == 0);
            @(negedge clk);
        end
        check("bounce_held", {30'd0, key_held}, 32'd0);
        key1_raw = 1'b1;
        expect_pulse(2'b10);
        wait_cycles(12);
        check("bounce_settled", {30'd0, key_held}, 32'd2);
        key1_raw = 1'b0;
        wait_cycles(12);

        // Release bounce on key0, then a genuine release.
        key0_raw = 1'b1;
        expect_pulse(2'b01);
        wait_cycles(12);
        check("rb_held", {31'd0, key_held[0]}, 32'd1);
        key0_raw = 1'b0;
        wait_cycles(2);
        key0_raw = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("rb_glitch_held", {31'd0, key_held[0]}, 32'd1);
        end
        key0_raw = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            check("rb_release", {31'd0, key_held[0]}, (i < PULSE_LAT) ? 32'd1 : 32'd0);
        end
        wait_cycles(4);

        // Simultaneous rise on both keys.
        key0_raw = 1'b1;
        key1_raw = 1'b1;
        expect_pulse(2'b11);
        wait_cycles(12);
        check("simul_held", {30'd0, key_held}, 32'd3);
        key0_raw = 1'b0;
        key1_raw = 1'b0;
        wait_cycles(12);

        // Lock-style sequence: key1, key0, key1, key0.
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) begin
                key1_raw = 1'b1;
                expect_pulse(2'b10);
            end else begin
                key0_raw = 1'b1;
                expect_pulse(2'b01);
            end
            wait_cycles(10);
            key0_raw = 1'b0;
            key1_raw = 1'b0;
            wait_cycles(10);
            check("seq_released", {30'd0, key_held}, 32'd0);
        end

        wait_cycles(5);
        check("sb_empty", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
